// File: rtl/serial_adder_arbiter.sv
// Two-requester front end for one shared bit-serial adder.
// Round-robin arbitration picks a requester. The winner's operands are then
// added LSB-first through two half adders and a carry flip-flop, one bit per
// clock. The registered result comes back with a done pulse and the requester ID.
module serial_adder_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             owner;
    logic             owner_next;
    logic             last;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic             p;
    logic             g;
    logic             s;
    logic             t;
    logic             carry_next;
    logic             last_bit;

    assign last_bit = (cnt == LAST_BIT);

    // Next-state logic. Arbitration happens only in IDLE, and a tie goes to the requester not served last.
    always_comb begin
        state_next = state;
        owner_next = owner;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    owner_next = ~last;
                    state_next = LOAD;
                end else if (req0) begin
                    owner_next = 1'b0;
                    state_next = LOAD;
                end else if (req1) begin
                    owner_next = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD:    state_next = ADD;
            ADD:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One bit slice of the serial adder: two half adders feeding the carry flop.
    always_comb begin
        p          = a_sh[0] ^ b_sh[0];
        g          = a_sh[0] & b_sh[0];
        s          = p ^ carry;
        t          = p & carry;
        carry_next = g | t;
        res_next   = (res_sh >> 1) | (WIDTH'(s) << (WIDTH - 1));
    end

    // State register. It also holds the requester currently being served.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= 1'b0;
        end else begin
            state <= state_next;
            owner <= owner_next;
        end
    end

    // Registered handshake outputs, derived from the upcoming state so that each one lines up with its own cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            gnt0 <= (state == IDLE) && (state_next == LOAD) && !owner_next;
            gnt1 <= (state == IDLE) && (state_next == LOAD) && owner_next;
            busy <= (state_next != IDLE);
            done <= (state == ADD) && last_bit;
        end
    end

    // Serial datapath: load the operands, shift them out one bit per cycle, and publish the result after the last bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            last    <= 1'b1;
            sum     <= '0;
            cout    <= 1'b0;
            done_id <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    a_sh  <= owner ? a1 : a0;
                    b_sh  <= owner ? b1 : b0;
                    carry <= 1'b0;
                    cnt   <= '0;
                    last  <= owner;
                end
                ADD: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    carry  <= carry_next;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        sum     <= res_next;
                        cout    <= carry_next;
                        done_id <= owner;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_arbiter.sv
// Testbench for serial_adder_arbiter. It uses directed scenarios followed by random request traffic.
// A transaction-level reference model predicts grants and results into a scoreboard.
// A separate monitor checks the DUT against that scoreboard every cycle.
module tb_serial_adder_arbiter;

    localparam int W = 8;

    typedef struct {
        logic         id;
        logic [W-1:0] sum;
        logic         cout;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0, req1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         gnt0, gnt1, busy, done, done_id, cout;
    logic [W-1:0] sum;

    serial_adder_arbiter #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .a0      (a0),
        .b0      (b0),
        .req1    (req1),
        .a1      (a1),
        .b1      (b1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .sum     (sum),
        .cout    (cout)
    );

    always #5 clk = ~clk;

    // Scoreboard and reference-model state.
    exp_t exp_q[$];
    int   cyc       = 0;
    int   free_at   = 0;
    int   gnt_cyc   = -1;
    logic gnt_id    = 1'b0;
    int   busy_lo   = -1;
    int   busy_hi   = -2;
    int   done_cyc  = -1;
    int   rst_cyc   = -1;
    int   flush_idx = 0;
    logic last_id   = 1'b1;
    logic [W:0] full_sum;
    exp_t m_e;

    // Monitor state and counters.
    int           rd        = 0;
    int           check_cnt = 0;
    int           pass_cnt  = 0;
    int           timeouts  = 0;
    logic [3:0]   exp_ctrl;
    logic [W-1:0] held_sum;
    logic         held_cout;
    logic         held_id;
    exp_t         c_e;
    logic         drain_req  = 1'b0;
    logic         drain_done = 1'b0;

    // Reference model. It samples the requests that the DUT sees at each edge.
    // The DUT is free when no operation is in flight. A grant follows one cycle after the request,
    // done arrives W+1 cycles after the grant, and the block is free again one cycle after done.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            rst_cyc   = cyc;
            flush_idx = exp_q.size();
            free_at   = cyc;
            last_id   = 1'b1;
            gnt_cyc   = -1;
            busy_lo   = -1;
            busy_hi   = -2;
            done_cyc  = -1;
        end else if ((cyc - 1) >= free_at && (req0 || req1)) begin
            if (req0 && req1) gnt_id = ~last_id;
            else              gnt_id = req0 ? 1'b0 : 1'b1;
            if (gnt_id == 1'b0) full_sum = {1'b0, a0} + {1'b0, b0};
            else                full_sum = {1'b0, a1} + {1'b0, b1};
            m_e.id   = gnt_id;
            m_e.sum  = full_sum[W-1:0];
            m_e.cout = full_sum[W];
            exp_q.push_back(m_e);
            gnt_cyc  = cyc;
            busy_lo  = cyc;
            busy_hi  = cyc + W + 1;
            done_cyc = cyc + W + 1;
            free_at  = cyc + W + 2;
            last_id  = gnt_id;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        check_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
    endtask

    // Monitor. Each cycle it checks the handshake outputs against the model's timing.
    // On every done it takes the next scoreboard entry and checks the result outputs against it.
    always @(negedge clk) begin
        if (rst_cyc >= 0 && cyc >= rst_cyc) begin
            if (cyc == rst_cyc) begin
                held_sum  = '0;
                held_cout = 1'b0;
                held_id   = 1'b0;
                if (rd < flush_idx) rd = flush_idx;
            end
            exp_ctrl = {(cyc == gnt_cyc) && !gnt_id, (cyc == gnt_cyc) && gnt_id,
                        (cyc >= busy_lo) && (cyc <= busy_hi), (cyc == done_cyc)};
            checkOutput("gnt0/gnt1/busy/done", 64'({gnt0, gnt1, busy, done}), 64'(exp_ctrl));
            if (done === 1'b1) begin
                if (rd < exp_q.size()) begin
                    c_e       = exp_q[rd];
                    rd        = rd + 1;
                    held_sum  = c_e.sum;
                    held_cout = c_e.cout;
                    held_id   = c_e.id;
                end else begin
                    check_cnt++;
                    $display("[TB] FAIL done with empty scoreboard at cycle %0d: got done=1, expected no result", cyc);
                end
            end
            checkOutput("done_id/cout/sum", 64'({done_id, cout, sum}), 64'({held_id, held_cout, held_sum}));
        end
        if (drain_req && !drain_done) begin
            checkOutput("scoreboard drained", 64'(rd), 64'(exp_q.size()));
            drain_done = 1'b1;
        end
    end

    function automatic logic [W-1:0] randOp();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raise one requester, wait (bounded) for its grant, and drop the request in the grant cycle.
    task automatic applyStimulus(input int id, input logic [W-1:0] a, input logic [W-1:0] b, output int gcyc);
        if (id == 0) begin a0 = a; b0 = b; req0 = 1'b1; end
        else         begin a1 = a; b1 = b; req1 = 1'b1; end
        gcyc = -1;
        for (int i = 0; i < 64 && gcyc < 0; i++) begin
            @(negedge clk);
            if ((id == 0 && gnt0 === 1'b1) || (id == 1 && gnt1 === 1'b1)) gcyc = cyc;
        end
        if (id == 0) req0 = 1'b0;
        else         req1 = 1'b0;
        if (gcyc < 0) begin
            timeouts++;
            $display("[TB] FAIL grant wait req%0d: got no grant in 64 cycles, expected one", id);
        end
    endtask

    task automatic waitDone();
        bit seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            timeouts++;
            $display("[TB] FAIL done wait: got no done in 64 cycles, expected one");
        end
    endtask

    // Raise both requesters at once and drop both as soon as either one is granted.
    task automatic applyTie();
        bit seen = 1'b0;
        a0 = randOp(); b0 = randOp(); a1 = randOp(); b1 = randOp();
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (gnt0 === 1'b1 || gnt1 === 1'b1) seen = 1'b1;
        end
        req0 = 1'b0; req1 = 1'b0;
        if (!seen) begin
            timeouts++;
            $display("[TB] FAIL tie grant wait: got no grant in 64 cycles, expected one");
        end
    endtask

    initial begin
        int g;
        int grants;
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        $display("[TB] basic add on requester 0");
        applyStimulus(0, 8'h5A, 8'h3C, g);
        waitDone();
        tick(1);

        $display("[TB] overflow and zero on requester 1");
        applyStimulus(1, 8'hFF, 8'h01, g);
        waitDone();
        applyStimulus(1, 8'h00, 8'h00, g);
        waitDone();
        tick(2);

        $display("[TB] both requesters held, alternating grants");
        grants = 0;
        a0 = randOp(); b0 = randOp(); a1 = randOp(); b1 = randOp();
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 200 && grants < 4; i++) begin
            @(negedge clk);
            if (gnt0 === 1'b1) begin grants++; req0 = 1'b0; end
            else if (!req0) begin a0 = randOp(); b0 = randOp(); req0 = 1'b1; end
            if (gnt1 === 1'b1) begin grants++; req1 = 1'b0; end
            else if (!req1) begin a1 = randOp(); b1 = randOp(); req1 = 1'b1; end
        end
        req0 = 1'b0; req1 = 1'b0;
        if (grants < 4) begin
            timeouts++;
            $display("[TB] FAIL alternating grants: got %0d grants, expected 4", grants);
        end
        waitDone();
        tick(2);

        $display("[TB] reset during the add, then tie after reset");
        applyStimulus(0, randOp(), randOp(), g);
        tick(5);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        applyTie();
        waitDone();
        tick(2);

        $display("[TB] back-to-back requests from requester 0");
        applyStimulus(0, randOp(), randOp(), g);
        waitDone();
        applyStimulus(0, randOp(), randOp(), g);
        waitDone();
        tick(2);

        $display("[TB] requester 1 pulsed only while busy");
        applyStimulus(0, randOp(), randOp(), g);
        tick(2);
        a1 = randOp(); b1 = randOp(); req1 = 1'b1;
        tick(4);
        req1 = 1'b0;
        waitDone();
        tick(2);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (req0 && gnt0 === 1'b1) req0 = 1'b0;
            else if (req0 && $urandom_range(0, 15) == 0) req0 = 1'b0;
            else if (!req0 && $urandom_range(0, 3) == 0) begin a0 = randOp(); b0 = randOp(); req0 = 1'b1; end
            if (req1 && gnt1 === 1'b1) req1 = 1'b0;
            else if (req1 && $urandom_range(0, 15) == 0) req1 = 1'b0;
            else if (!req1 && $urandom_range(0, 3) == 0) begin a1 = randOp(); b1 = randOp(); req1 = 1'b1; end
        end
        req0 = 1'b0; req1 = 1'b0;
        tick(W + 6);
        drain_req = 1'b1;
        tick(3);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt + timeouts);
        $finish;
    end

endmodule
